// File: rtl/sampler_pkg.sv
// Shared types and helpers for the constraint sample driver: FSM states,
// Galois LFSR polynomial/step and the fill-beat count.
package sampler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CHECK,
        EMIT,
        DONE
    } state_t;

    localparam int LFSR_BITS = 64;

    // Right-shifting Galois form of x^64 + x^63 + x^61 + x^60 + 1.
    localparam logic [LFSR_BITS-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    function automatic logic [LFSR_BITS-1:0] galois_step(input logic [LFSR_BITS-1:0] s);
        return s[0] ? ({1'b0, s[LFSR_BITS-1:1]} ^ LFSR_TAPS) : {1'b0, s[LFSR_BITS-1:1]};
    endfunction

    function automatic int fill_beats(input int cand_w, input int lfsr_w);
        return (cand_w + lfsr_w - 1) / lfsr_w;
    endfunction

endpackage

// File: rtl/sampler_lfsr.sv
// 64-bit Galois LFSR with synchronous load and step enable.
// Load values are expected to be non-zero so the register never locks up.
module sampler_lfsr
    import sampler_pkg::*;
#(
    parameter logic [LFSR_BITS-1:0] SEED = 64'hACE1_0000_1234_5678
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [LFSR_BITS-1:0] load_value,
    input  logic                 step,
    output logic [LFSR_BITS-1:0] state_o
);

    logic [LFSR_BITS-1:0] state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else if (load) begin
            state_q <= load_value;
        end else if (step) begin
            state_q <= galois_step(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/constraint_sample_driver.sv
// Builds pseudo-random candidates beat by beat, samples the checker's sat bit
// and streams satisfying candidates out over a valid/ready port.
module constraint_sample_driver
    import sampler_pkg::*;
#(
    parameter int              CAND_W = 779,
    parameter int              LFSR_W = 64,
    parameter int              CNT_W  = 32,
    parameter logic [LFSR_W-1:0] SEED = 64'hACE1_0000_1234_5678
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic [CNT_W-1:0]  num_samples_i,
    input  logic [CNT_W-1:0]  max_attempts_i,
    output logic [CAND_W-1:0] cand_o,
    input  logic              sat_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CAND_W-1:0] out_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  attempts_o,
    output logic [CNT_W-1:0]  samples_o
);

    localparam int FILL_BEATS = fill_beats(CAND_W, LFSR_W);
    localparam int BEAT_W     = (FILL_BEATS > 1) ? $clog2(FILL_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FILL_BEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_next, lfsr_seed;
    logic               lfsr_load, lfsr_step;
    logic [CAND_W-1:0]  cand_q, cand_fill, out_data_q;
    logic [CNT_W-1:0]   num_q, max_q, attempts_q, samples_q;
    logic [CNT_W-1:0]   attempts_inc, samples_inc;
    logic               timeout_q;
    logic               last_beat, budget_hit;

    assign lfsr_seed    = (seed_i == '0) ? SEED : seed_i;
    assign lfsr_next    = galois_step(lfsr_q);
    assign attempts_inc = attempts_q + CNT_ONE;
    assign samples_inc  = samples_q + CNT_ONE;
    assign last_beat    = (beat_q == LAST_BEAT);
    assign budget_hit   = (max_q != '0) && (attempts_inc == max_q);

    sampler_lfsr #(.SEED(SEED)) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load),
        .load_value (lfsr_seed),
        .step       (lfsr_step),
        .state_o    (lfsr_q)
    );

    // Each beat overwrites one LFSR-wide slice; the top slice is truncated.
    for (genvar b = 0; b < FILL_BEATS; b++) begin : g_beat
        localparam int LO = b * LFSR_W;
        localparam int HI = (LO + LFSR_W > CAND_W) ? CAND_W - 1 : LO + LFSR_W - 1;
        assign cand_fill[HI:LO] = (beat_q == BEAT_W'(b)) ? lfsr_next[HI-LO:0] : cand_q[HI:LO];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    lfsr_load = 1'b1;
                    state_d   = (num_samples_i == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                lfsr_step = 1'b1;
                if (last_beat) state_d = CHECK;
            end
            CHECK: begin
                if (sat_i)           state_d = EMIT;
                else if (budget_hit) state_d = DONE;
                else                 state_d = FILL;
            end
            EMIT: begin
                if (out_ready_i) state_d = (samples_inc == num_q) ? DONE : FILL;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q     <= '0;
            cand_q     <= '0;
            out_data_q <= '0;
            num_q      <= '0;
            max_q      <= '0;
            attempts_q <= '0;
            samples_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        num_q      <= num_samples_i;
                        max_q      <= max_attempts_i;
                        attempts_q <= '0;
                        samples_q  <= '0;
                        timeout_q  <= 1'b0;
                        beat_q     <= '0;
                    end
                end
                FILL: begin
                    cand_q <= cand_fill;
                    beat_q <= last_beat ? '0 : beat_q + 1'b1;
                end
                CHECK: begin
                    if (attempts_q != '1) attempts_q <= attempts_inc;
                    if (sat_i)            out_data_q <= cand_q;
                    else if (budget_hit)  timeout_q  <= 1'b1;
                end
                EMIT: begin
                    if (out_ready_i) samples_q <= samples_inc;
                end
                default: ;
            endcase
        end
    end

    // valid/ready: a sample transfers on any cycle where out_valid_o and
    // out_ready_i are both high; until then valid and data are held.
    assign cand_o      = cand_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = (state_q == EMIT);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign timeout_o   = (state_q == DONE) && timeout_q;
    assign attempts_o  = attempts_q;
    assign samples_o   = samples_q;

endmodule

// File: tb/tb_constraint_sample_driver.sv
// Directed bench for constraint_sample_driver with an LFSR reference model
// feeding an expected-sample queue that a separate monitor drains.
module tb_constraint_sample_driver;

  localparam int CAND_W = 779;
  localparam int LFSR_W = 64;
  localparam int CNT_W  = 32;
  localparam logic [63:0] SEED = 64'hACE1_0000_1234_5678;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [LFSR_W-1:0] seed_i;
  logic [CNT_W-1:0]  num_samples_i;
  logic [CNT_W-1:0]  max_attempts_i;
  logic [CAND_W-1:0] cand_o;
  logic              sat_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CAND_W-1:0] out_data_o;
  logic              busy_o;
  logic              done_o;
  logic              timeout_o;
  logic [CNT_W-1:0]  attempts_o;
  logic [CNT_W-1:0]  samples_o;

  int tests = 0;
  int fails = 0;
  int sat_mode = 0;  // 0: sat = cand[0], 1: sat = 0, 2: sat = 1
  logic [CAND_W-1:0] exp_q[$];
  logic prev_stall = 1'b0;

  constraint_sample_driver dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .seed_i         (seed_i),
    .num_samples_i  (num_samples_i),
    .max_attempts_i (max_attempts_i),
    .cand_o         (cand_o),
    .sat_i          (sat_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .timeout_o      (timeout_o),
    .attempts_o     (attempts_o),
    .samples_o      (samples_o)
  );

  // ---------------- clock / checker stub ----------------
  always #5 clk = ~clk;

  always_comb begin
    sat_i = 1'b0;
    case (sat_mode)
      0: sat_i = cand_o[0];
      2: sat_i = 1'b1;
      default: sat_i = 1'b0;
    endcase
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] step64(input logic [63:0] s);
    logic [63:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 64'hD800_0000_0000_0000;
    return n;
  endfunction

  task automatic model_run(input logic [63:0] seed, input int num, input int max_att,
                           input int mode, output int att, output logic tmo,
                           output logic [CAND_W-1:0] first);
    logic [63:0] s;
    logic [CAND_W-1:0] c;
    logic sat;
    int smp;
    int idx;
    s = (seed == 64'd0) ? SEED : seed;
    c = '0;
    first = '0;
    att = 0;
    tmo = 1'b0;
    smp = 0;
    while (smp < num && att < 100000) begin
      for (int b = 0; b < 13; b++) begin
        s = step64(s);
        for (int i = 0; i < 64; i++) begin
          idx = b * 64 + i;
          if (idx < CAND_W) c[idx] = s[i];
        end
      end
      att++;
      if (att == 1) first = c;
      sat = (mode == 0) ? c[0] : (mode == 2);
      if (sat) begin
        exp_q.push_back(c);
        smp++;
      end else if (max_att != 0 && att == max_att) begin
        tmo = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cand(input string name, input logic [CAND_W-1:0] act,
                            input logic [CAND_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got low64 %0h expected low64 %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests++;
        if (!out_valid_o) begin
          fails++;
          $display("FAIL valid_drop: got valid 0 expected 1");
        end
      end
      if (out_valid_o && out_ready_i) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_sample: got low64 %0h expected none", out_data_o[63:0]);
        end else begin
          logic [CAND_W-1:0] e;
          e = exp_q.pop_front();
          if (out_data_o !== e) begin
            fails++;
            $display("FAIL sample_data: got low64 %0h expected low64 %0h",
                     out_data_o[63:0], e[63:0]);
          end
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [63:0] seed, input int num, input int max_att);
    seed_i         = seed;
    num_samples_i  = num;
    max_attempts_i = max_att;
    start_i        = 1'b1;
    @(posedge clk); #1;
    start_i        = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the edge that accepted start.
  task automatic wait_done(input int budget, output int cyc, output logic tmo);
    logic got;
    got = 1'b0;
    cyc = 0;
    tmo = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        cyc = i;
        tmo = timeout_o;
        break;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL done_wait: got no done_o expected done within %0d cycles", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid_o) begin
        got = 1'b1;
        break;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL valid_wait: got no out_valid_o expected within %0d cycles", budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int att;
    int cyc;
    logic tmo;
    logic tmo_seen;
    logic [CAND_W-1:0] first;

    rst = 1'b1;
    start_i = 1'b0;
    seed_i = '0;
    num_samples_i = '0;
    max_attempts_i = '0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_attempts", attempts_o, 0);
    check("rst_samples", samples_o, 0);
    check_cand("rst_cand", cand_o, '0);
    check_cand("rst_out_data", out_data_o, '0);
    @(posedge clk); #1;

    // num=0: straight to DONE; start held into the DONE cycle is ignored.
    seed_i = 64'd1;
    num_samples_i = '0;
    max_attempts_i = '0;
    start_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("n0_done", done_o, 1);
    check("n0_timeout", timeout_o, 0);
    check("n0_valid", out_valid_o, 0);
    check_cand("n0_cand", cand_o, '0);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("n0_back_idle", busy_o, 0);
    check("n0_done_pulse", done_o, 0);
    check("n0_samples", samples_o, 0);
    @(posedge clk); #1;

    // sat = cand[0], seed 1, four samples, unlimited budget.
    sat_mode = 0;
    out_ready_i = 1'b1;
    model_run(64'd1, 4, 0, 0, att, tmo, first);
    start_run(64'd1, 4, 0);
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("t1_beat0", cand_o[63:0], 64'hD800_0000_0000_0000);
    check_cand("t1_first_cand", cand_o, first);
    @(posedge clk); #1;
    wait_done(20000, cyc, tmo_seen);
    check("t1_timeout", tmo_seen, 0);
    check("t1_attempts", attempts_o, att);
    check("t1_samples", samples_o, 4);
    check("t1_queue_empty", exp_q.size(), 0);

    // Never satisfied, budget 5: CHECKs at cycles 14,28,..,70, DONE at 71.
    sat_mode = 1;
    model_run(64'd7, 1, 5, 1, att, tmo, first);
    start_run(64'd7, 1, 5);
    wait_done(200, cyc, tmo_seen);
    check("t2_done_cycle", cyc, 71);
    check("t2_timeout", tmo_seen, 1);
    check("t2_attempts", attempts_o, 5);
    check("t2_model_attempts", att, 5);
    check("t2_samples", samples_o, 0);

    // Always satisfied with the sink stalled for 20 cycles.
    sat_mode = 2;
    out_ready_i = 1'b0;
    model_run(64'd3, 1, 0, 2, att, tmo, first);
    start_run(64'd3, 1, 0);
    wait_valid(100);
    for (int k = 0; k < 20; k++) begin
      check("t4_valid_held", out_valid_o, 1);
      check_cand("t4_data_stable", out_data_o, first);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    wait_done(100, cyc, tmo_seen);
    check("t4_samples", samples_o, 1);
    check("t4_attempts", attempts_o, 1);
    check("t4_timeout", tmo_seen, 0);

    // Reset in cycle 7 of FILL, then a fresh seed-1 run.
    sat_mode = 0;
    start_run(64'd1, 2, 0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_attempts", attempts_o, 0);
    check_cand("t5_rst_cand", cand_o, '0);
    @(posedge clk); #1;
    model_run(64'd1, 2, 0, 0, att, tmo, first);
    start_run(64'd1, 2, 0);
    repeat (13) @(posedge clk);
    @(negedge clk);
    check_cand("t5_first_cand", cand_o, first);
    @(posedge clk); #1;
    wait_done(20000, cyc, tmo_seen);
    check("t5_attempts", attempts_o, att);
    check("t5_samples", samples_o, 2);

    // seed 0 selects SEED; start pulses in FILL and EMIT are ignored.
    sat_mode = 0;
    out_ready_i = 1'b0;
    model_run(64'd0, 2, 0, 0, att, tmo, first);
    start_run(64'd0, 2, 0);
    repeat (4) @(posedge clk);
    #1;
    seed_i = 64'd5;
    num_samples_i = 9;
    max_attempts_i = 1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_valid(20000);
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    out_ready_i = 1'b1;
    wait_done(20000, cyc, tmo_seen);
    check("t6_attempts", attempts_o, att);
    check("t6_samples", samples_o, 2);
    check("t6_timeout", tmo_seen, 0);
    check("t6_queue_empty", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
